cw305_usb_bus_master: RTL and testbench

Bus initiator for the CW305 parallel USB register bus: turns byte-burst commands from a simple valid/ready interface into correctly sequenced `usb_cen`/`usb_addr`/`usb_rdn`/`usb_wrn`/data cycles. It drives the same pins the target-side register front end decodes. It serves as the host-side model in simulation and as an on-FPGA bridge for loopback self-test of the register blocks. One byte moves per bus cycle. Bursts step the byte-count field of the address.

---
 rtl/cw305_usb_bus_pkg.sv | 26 ++
 rtl/cw305_bus_phase_timer.sv | 30 +++
 rtl/cw305_usb_bus_master.sv | 173 +++++++++++++++++
 tb/tb_cw305_usb_bus_master.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cw305_usb_bus_pkg.sv
// Shared types and sizing helpers for the CW305 USB register-bus initiator.
// Holds the sequencer state encoding and the phase-counter width.
package cw305_usb_bus_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_WD,
      SETUP,
      STROBE,
      HOLD,
      WAIT_RD,
      FINISH
   } bus_state_e;

   // Counter holds (phase length - 1), so clog2 of the longest phase suffices
   function automatic int phase_w(input int s, input int t, input int h);
      int m;
      m = s;
      if (t > m) m = t;
      if (h > m) m = h;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

   localparam int PHASE_W = phase_w(1, 2, 1);

endpackage

// File: rtl/cw305_bus_phase_timer.sv
// Loadable down-counter timing one bus phase.
// last_o is high on the final cycle of the loaded phase.
module cw305_bus_phase_timer #(
   parameter int W = 1
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         last_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (cnt_q != '0)
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign last_o = (cnt_q == '0);

endmodule

// File: rtl/cw305_usb_bus_master.sv
// Host-side initiator for the CW305 parallel USB register bus.
// Sequences byte bursts as SETUP/STROBE/HOLD cycles on the bus pins.
module cw305_usb_bus_master
   import cw305_usb_bus_pkg::*;
#(
   parameter int pADDR_WIDTH    = 21,
   parameter int pBYTECNT_SIZE  = 7,
   parameter int pSETUP_CYCLES  = 1,
   parameter int pSTROBE_CYCLES = 2,
   parameter int pHOLD_CYCLES   = 1
) (
   input  logic                     usb_clk,
   input  logic                     rst,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic                     cmd_write,
   input  logic [pADDR_WIDTH-1:0]   cmd_addr,
   input  logic [pBYTECNT_SIZE-1:0] cmd_len,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   input  logic [7:0]               wr_data,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   output logic [7:0]               rd_data,
   output logic                     done,
   output logic [pADDR_WIDTH-1:0]   usb_addr,
   output logic [7:0]               usb_dout,
   input  logic [7:0]               usb_din,
   output logic                     usb_oe,
   output logic                     usb_cen,
   output logic                     usb_rdn,
   output logic                     usb_wrn
);

   localparam int PW = phase_w(pSETUP_CYCLES, pSTROBE_CYCLES, pHOLD_CYCLES);
   localparam int BC = pBYTECNT_SIZE;

   bus_state_e             state_q, state_d;
   logic                   write_q, write_d;
   logic [pADDR_WIDTH-1:0] addr_q, addr_d;
   logic [BC-1:0]          len_q, len_d;
   logic [BC-1:0]          idx_q, idx_d;
   logic [7:0]             dout_q, dout_d;
   logic [7:0]             rdata_q, rdata_d;
   logic                   rvalid_q, rvalid_d;

   logic          ph_load, ph_last;
   logic [PW-1:0] ph_val;
   logic          rd_pend, last_byte, in_burst;

   // A byte handed over this very cycle counts as already taken
   assign rd_pend   = rvalid_q & ~rd_ready;
   assign last_byte = (idx_q == len_q);

   always_comb begin
      state_d  = state_q;
      write_d  = write_q;
      addr_d   = addr_q;
      len_d    = len_q;
      idx_d    = idx_q;
      dout_d   = dout_q;
      rdata_d  = rdata_q;
      rvalid_d = rvalid_q;
      if (rvalid_q && rd_ready) rvalid_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               write_d = cmd_write;
               addr_d  = cmd_addr;
               len_d   = cmd_len;
               idx_d   = '0;
               state_d = cmd_write ? WAIT_WD : SETUP;
            end
         end
         WAIT_WD: begin
            if (wr_valid) begin
               dout_d  = wr_data;
               state_d = SETUP;
            end
         end
         SETUP: begin
            if (ph_last) state_d = STROBE;
         end
         STROBE: begin
            if (ph_last) begin
               state_d = HOLD;
               if (!write_q) begin
                  rdata_d  = usb_din;
                  rvalid_d = 1'b1;
               end
            end
         end
         HOLD: begin
            if (ph_last) begin
               if (last_byte) begin
                  state_d = FINISH;
               end else begin
                  idx_d  = idx_q + 1'b1;
                  // Byte counter field wraps without carrying upward
                  addr_d[BC-1:0] = addr_q[BC-1:0] + 1'b1;
                  if (write_q)      state_d = WAIT_WD;
                  else if (rd_pend) state_d = WAIT_RD;
                  else              state_d = SETUP;
               end
            end
         end
         WAIT_RD: begin
            if (!rd_pend) state_d = SETUP;
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ph_load = (state_d != state_q);
      case (state_d)
         SETUP:   ph_val = PW'(pSETUP_CYCLES - 1);
         STROBE:  ph_val = PW'(pSTROBE_CYCLES - 1);
         HOLD:    ph_val = PW'(pHOLD_CYCLES - 1);
         default: ph_val = '0;
      endcase
   end

   cw305_bus_phase_timer #(
      .W (PW)
   ) u_timer (
      .clk_i      (usb_clk),
      .rst_i      (rst),
      .load_i     (ph_load),
      .load_val_i (ph_val),
      .last_o     (ph_last)
   );

   always_ff @(posedge usb_clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         write_q  <= 1'b0;
         addr_q   <= '0;
         len_q    <= '0;
         idx_q    <= '0;
         dout_q   <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         write_q  <= write_d;
         addr_q   <= addr_d;
         len_q    <= len_d;
         idx_q    <= idx_d;
         dout_q   <= dout_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
      end
   end

   // Chip enable stays low across inter-byte waits inside a burst
   assign in_burst = (state_q inside {SETUP, STROBE, HOLD, WAIT_RD}) ||
                     (state_q == WAIT_WD && idx_q != '0);

   assign cmd_ready = (state_q == IDLE) & ~rst;
   assign wr_ready  = (state_q == WAIT_WD);
   assign rd_valid  = rvalid_q;
   assign rd_data   = rdata_q;
   assign done      = (state_q == FINISH);
   assign usb_addr  = addr_q;
   assign usb_dout  = dout_q;
   assign usb_cen   = ~in_burst;
   assign usb_oe    = write_q & in_burst;
   assign usb_rdn   = ~((state_q == STROBE) & ~write_q);
   assign usb_wrn   = ~((state_q == STROBE) & write_q);

endmodule

// File: tb/tb_cw305_usb_bus_master.sv
// Directed bench for cw305_usb_bus_master with a transaction-level
// bus model, a write-data feeder and a read-data consumer.
module tb_cw305_usb_bus_master;

   typedef struct {
      bit          wr;
      logic [20:0] addr;
      logic [7:0]  data;
   } xfer_t;

   typedef struct {
      logic [7:0] data;
      int         stall;
   } wbyte_t;

   logic        clk = 0;
   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [20:0] cmd_addr;
   logic [6:0]  cmd_len;
   logic        wr_valid, wr_ready;
   logic [7:0]  wr_data;
   logic        rd_valid, rd_ready;
   logic [7:0]  rd_data;
   logic        done;
   logic [20:0] usb_addr;
   logic [7:0]  usb_dout, usb_din;
   logic        usb_oe, usb_cen, usb_rdn, usb_wrn;

   int n_chk = 0;
   int n_fail = 0;

   xfer_t       exp_q[$];
   wbyte_t      wr_feed[$];
   logic [7:0]  rd_exp[$];
   logic [20:0] addr_log[$];
   logic [7:0]  dout_log[$];
   logic [7:0]  rd_log[$];
   logic [7:0]  mem [int];

   int strobes = 0;
   int dones = 0;
   int last_gap = 0;
   int cen_run = 0;
   int rd_hold = 0;
   bit wr_sched = 0;
   bit rd_sched = 0;
   logic [7:0] rd_cap;

   always #5 clk = ~clk;

   cw305_usb_bus_master dut (
      .usb_clk   (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_len   (cmd_len),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_data   (wr_data),
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready),
      .rd_data   (rd_data),
      .done      (done),
      .usb_addr  (usb_addr),
      .usb_dout  (usb_dout),
      .usb_din   (usb_din),
      .usb_oe    (usb_oe),
      .usb_cen   (usb_cen),
      .usb_rdn   (usb_rdn),
      .usb_wrn   (usb_wrn)
   );

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] resp(input logic [20:0] a);
      if (mem.exists(int'(a))) return mem[int'(a)];
      return a[7:0] ^ 8'h5A;
   endfunction

   // Address of byte i: low 7 bits wrap mod 128, upper bits fixed
   function automatic logic [20:0] step(input logic [20:0] a, input int i);
      int lo;
      lo = (int'(a[6:0]) + i) % 128;
      return (a & ~21'h7F) | 21'(lo);
   endfunction

   // Responder: drives read data for whatever address is on the bus
   always @(negedge clk) usb_din = resp(usb_addr);

   // Write-data feeder; stalls count only cycles the DUT is asking
   always @(negedge clk) begin
      if (rst) begin
         wr_valid = 0;
         wr_sched = 0;
      end else begin
         if (wr_sched && wr_feed.size() > 0) void'(wr_feed.pop_front());
         wr_valid = 0;
         if (wr_feed.size() > 0) begin
            if (wr_feed[0].stall > 0) begin
               if (wr_ready) begin
                  wbyte_t f;
                  f = wr_feed[0];
                  f.stall--;
                  wr_feed[0] = f;
               end
            end else begin
               wr_valid = 1;
               wr_data = wr_feed[0].data;
            end
         end
         wr_sched = wr_valid && wr_ready;
      end
   end

   // Read-data consumer with an optional hold-off
   always @(negedge clk) begin
      if (rst) begin
         rd_sched = 0;
      end else begin
         if (rd_sched) begin
            if (rd_exp.size() == 0) chk("rd_unexpected", 1, 0);
            else begin
               logic [7:0] e;
               e = rd_exp.pop_front();
               chk("rd_data", rd_cap, e);
            end
            rd_log.push_back(rd_cap);
         end
         rd_ready = (rd_hold == 0);
         if (rd_hold > 0) rd_hold--;
         rd_sched = rd_valid && rd_ready;
         rd_cap = rd_data;
      end
   end

   // Bus monitor: checks every strobe window against the model queue
   bit          win_on = 0;
   bit          win_wr;
   int          win_len;
   logic [20:0] win_addr;
   logic [7:0]  win_dout;
   logic        prev_cen = 1;
   logic [20:0] prev_addr;
   logic [7:0]  prev_dout;

   always @(negedge clk) begin
      if (rst) begin
         win_on = 0;
         prev_cen = 1;
         cen_run = 0;
      end else begin
         if (!usb_rdn || !usb_wrn) begin
            chk("strobe_excl", usb_rdn | usb_wrn, 1);
            chk("cen_in_strobe", usb_cen, 0);
            chk("oe_dir", usb_oe, !usb_wrn);
            if (!win_on) begin
               win_on = 1;
               win_len = 1;
               win_addr = usb_addr;
               win_dout = usb_dout;
               win_wr = !usb_wrn;
               chk("setup_cen", prev_cen, 0);
               chk("setup_addr", prev_addr, usb_addr);
               if (win_wr) chk("setup_dout", prev_dout, usb_dout);
               else        chk("rd_free", rd_valid, 0);
            end else begin
               win_len++;
               chk("addr_stable", usb_addr, win_addr);
               chk("dout_stable", usb_dout, win_dout);
            end
         end else if (win_on) begin
            win_on = 0;
            chk("hold_cen", usb_cen, 0);
            chk("hold_addr", usb_addr, win_addr);
            if (win_wr) chk("hold_dout", usb_dout, win_dout);
            chk("strobe_len", win_len, 2);
            if (exp_q.size() == 0) chk("unexpected_strobe", 1, 0);
            else begin
               xfer_t e;
               e = exp_q.pop_front();
               chk("kind", win_wr, e.wr);
               chk("addr", win_addr, e.addr);
               if (e.wr) chk("wdata", win_dout, e.data);
            end
            addr_log.push_back(win_addr);
            dout_log.push_back(win_dout);
            strobes++;
         end
         if (cmd_ready) chk("oe_idle", usb_oe, 0);
         if (done) begin
            dones++;
            chk("cen_at_done", usb_cen, 1);
         end
         if (usb_cen) cen_run++;
         else begin
            if (prev_cen) last_gap = cen_run;
            cen_run = 0;
         end
         prev_cen = usb_cen;
         prev_addr = usb_addr;
         prev_dout = usb_dout;
      end
   end

   task automatic issue(input bit w, input logic [20:0] a, input int n,
                        input logic [7:0] base, input int stall_idx,
                        input int stall_n, input bit keep);
      bit ok;
      for (int i = 0; i < n; i++) begin
         xfer_t e;
         e.wr = w;
         e.addr = step(a, i);
         e.data = w ? 8'(int'(base) + i * 8'h11) : resp(e.addr);
         exp_q.push_back(e);
         if (w) begin
            wbyte_t b;
            b.data = e.data;
            b.stall = (i == stall_idx) ? stall_n : 0;
            wr_feed.push_back(b);
         end else begin
            rd_exp.push_back(e.data);
         end
      end
      cmd_write = w;
      cmd_addr = a;
      cmd_len = 7'(n - 1);
      cmd_valid = 1;
      ok = 0;
      for (int k = 0; k < 300; k++) begin
         if (cmd_ready) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) chk("cmd_accept_timeout", 0, 1);
      @(negedge clk);
      if (!keep) cmd_valid = 0;
   endtask

   task automatic wait_done(output int cyc, output int cen_hi);
      bit seen, ok;
      seen = 0;
      ok = 0;
      cen_hi = 0;
      cyc = -1;
      for (int n = 0; n < 400; n++) begin
         if (done) begin
            ok = 1;
            cyc = n;
            break;
         end
         if (!usb_cen) seen = 1;
         else if (seen) cen_hi++;
         @(negedge clk);
      end
      if (!ok) chk("done_timeout", 0, 1);
   endtask

   task automatic drain();
      for (int k = 0; k < 60; k++) begin
         if (exp_q.size() == 0 && rd_exp.size() == 0 &&
             wr_feed.size() == 0 && !rd_valid && cmd_ready) break;
         @(negedge clk);
      end
      repeat (2) @(negedge clk);
      chk("drain_empty", exp_q.size() + rd_exp.size(), 0);
   endtask

   logic [2:0] explat [4];

   initial begin
      int cyc, cen_hi, s0, d0;
      bit found;
      rst = 1;
      cmd_valid = 0;
      cmd_write = 0;
      cmd_addr = '0;
      cmd_len = '0;
      wr_valid = 0;
      wr_data = '0;
      rd_ready = 1;
      usb_din = '0;
      explat[0] = 3'b010;
      explat[1] = 3'b000;
      explat[2] = 3'b000;
      explat[3] = 3'b011;

      repeat (2) @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_values",
          {wr_ready, rd_valid, done, usb_oe, usb_addr, usb_dout,
           rd_data, usb_cen, usb_rdn, usb_wrn},
          {4'b0000, 21'h0, 8'h00, 8'h00, 3'b111});
      rst = 0;
      @(negedge clk);
      chk("post_rst_ready", cmd_ready, 1);

      // Single write
      s0 = strobes;
      d0 = dones;
      issue(1, 21'h000100, 1, 8'hA5, -1, 0, 0);
      wait_done(cyc, cen_hi);
      chk("t1_cycles", cyc, 5);
      drain();
      chk("t1_strobes", strobes - s0, 1);
      chk("t1_dones", dones - d0, 1);
      chk("t1_addr", addr_log[addr_log.size()-1], 21'h000100);
      chk("t1_dout", dout_log[dout_log.size()-1], 8'hA5);

      // 4-byte read across the byte-counter wrap
      mem[32'h27E] = 8'h11;
      mem[32'h27F] = 8'h22;
      mem[32'h200] = 8'h33;
      mem[32'h201] = 8'h44;
      addr_log.delete();
      rd_log.delete();
      issue(0, 21'h00027E, 4, 8'h00, -1, 0, 0);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("t2_lat%0d", k), {usb_cen, usb_rdn, rd_valid},
             explat[k]);
         if (k < 3) @(negedge clk);
      end
      wait_done(cyc, cen_hi);
      drain();
      chk("t2_nstrobe", addr_log.size(), 4);
      chk("t2_nread", rd_log.size(), 4);
      if (addr_log.size() == 4 && rd_log.size() == 4) begin
         chk("t2_a0", addr_log[0], 21'h00027E);
         chk("t2_a1", addr_log[1], 21'h00027F);
         chk("t2_a2", addr_log[2], 21'h000200);
         chk("t2_a3", addr_log[3], 21'h000201);
         chk("t2_d", {rd_log[0], rd_log[1], rd_log[2], rd_log[3]},
             32'h11223344);
      end

      // 3-byte write, data withheld 5 cycles before byte 2
      s0 = strobes;
      dout_log.delete();
      issue(1, 21'h012340, 3, 8'h30, 1, 5, 0);
      wait_done(cyc, cen_hi);
      chk("t3_cen_low", cen_hi, 0);
      chk("t3_cycles", cyc, 20);
      drain();
      chk("t3_strobes", strobes - s0, 3);
      if (dout_log.size() == 3)
         chk("t3_d", {dout_log[0], dout_log[1], dout_log[2]}, 24'h304152);
      else
         chk("t3_ndout", dout_log.size(), 3);

      // 2-byte read with the consumer stalled 10 cycles
      mem[32'hA0010] = 8'hC3;
      mem[32'hA0011] = 8'h3C;
      rd_log.delete();
      @(posedge clk);
      rd_hold = 10;
      @(negedge clk);
      issue(0, 21'h0A0010, 2, 8'h00, -1, 0, 0);
      wait_done(cyc, cen_hi);
      chk("t4_cycles", cyc, 14);
      drain();
      if (rd_log.size() == 2)
         chk("t4_d", {rd_log[0], rd_log[1]}, 16'hC33C);
      else
         chk("t4_nread", rd_log.size(), 2);

      // Reset during a mid-burst write strobe
      s0 = strobes;
      d0 = dones;
      issue(1, 21'h01FF7E, 3, 8'h70, -1, 0, 0);
      found = 0;
      for (int k = 0; k < 200; k++) begin
         if (strobes - s0 >= 1 && !usb_wrn) begin
            found = 1;
            break;
         end
         @(negedge clk);
      end
      chk("t5_found_strobe", found, 1);
      rst = 1;
      #1;
      chk("t5_async", {usb_wrn, usb_cen, usb_rdn, usb_oe, cmd_ready},
          5'b11100);
      exp_q.delete();
      wr_feed.delete();
      rd_exp.delete();
      repeat (2) @(negedge clk);
      rst = 0;
      @(negedge clk);
      chk("t5_ready", cmd_ready, 1);
      repeat (5) @(negedge clk);
      chk("t5_no_done", dones - d0, 0);
      chk("t5_strobes", strobes - s0, 1);

      // Back-to-back commands, cmd_valid held high
      d0 = dones;
      issue(1, 21'h000055, 1, 8'hE7, -1, 0, 1);
      issue(0, 21'h000056, 2, 8'h00, -1, 0, 0);
      wait_done(cyc, cen_hi);
      drain();
      chk("t6_dones", dones - d0, 2);
      chk("t6_gap", last_gap >= 1, 1);
      chk("end_rd_empty", rd_exp.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
